// File: rtl/phy_tx_lane_mux.sv
// rtl/phy_tx_lane_mux.sv - single-clock lane-group FIFO and serializer with recirculation path
// Optional build macro: PHY_TX_SKIP_INVALID_EN (serializer skips lanes whose valid bit is clear)
module phy_tx_lane_mux #(
  parameter int               LANES = 4,
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] IDLE  = WIDTH'(8'h7C),
  localparam int              LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   active,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic [LW-1:0]          lane_out,
  output logic [LANES*WIDTH-1:0] recirc_data,
  output logic                   recirc_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [LANES*WIDTH-1:0] r_fifo_data [DEPTH];
  logic [LANES-1:0]       r_fifo_mask [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW:0]            r_count;
  logic [PW:0]            r_count_next;
  logic [0:0]             r_state;
  logic [LW-1:0]          r_idx;

  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_emit;
  logic                   w_last;
  logic [LW-1:0]          w_cur;
  logic [LANES*WIDTH-1:0] w_head_data;
  logic [LANES-1:0]       w_head_mask;
  logic [WIDTH-1:0]       w_lane_data;
  logic                   w_lane_vld;

  assign w_full      = (r_count == (PW+1)'(DEPTH));
  assign in_ready    = active && !w_full;
  assign w_push      = active && (|in_valid) && !w_full;
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_mask = r_fifo_mask[r_rd_ptr];
  assign w_emit      = (r_state == S_SEND) || (r_count != '0);
  assign w_pop       = w_emit && w_last;
  assign w_lane_data = w_head_data[int'(w_cur)*WIDTH +: WIDTH];
  assign w_lane_vld  = w_head_mask[w_cur];

  // Pick the lane presented this cycle and whether it closes the head group.
  always_comb begin
    w_cur  = r_idx;
    w_last = (r_idx == LW'(LANES-1));
`ifdef PHY_TX_SKIP_INVALID_EN
    for (int i = LANES-1; i >= 0; i--) begin
      if (w_head_mask[i] && (LW'(i) >= r_idx)) w_cur = LW'(i);
    end
    w_last = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (w_head_mask[i] && (LW'(i) > w_cur)) w_last = 1'b0;
    end
`endif
  end

  always_comb begin
    r_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   r_count_next = r_count + 1'b1;
      2'b01:   r_count_next = r_count - 1'b1;
      default: r_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= in_data;
      r_fifo_mask[r_wr_ptr] <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_state      <= S_IDLE;
      r_idx        <= '0;
      data_out     <= IDLE;
      valid_out    <= 1'b0;
      lane_out     <= '0;
      recirc_data  <= '0;
      recirc_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count_next;
      r_state <= (r_count_next != '0) ? S_SEND : S_IDLE;

      if (w_emit) begin
        data_out  <= w_lane_vld ? w_lane_data : IDLE;
        valid_out <= w_lane_vld;
        lane_out  <= w_cur;
        r_idx     <= w_last ? '0 : w_cur + 1'b1;
      end else begin
        data_out  <= IDLE;
        valid_out <= 1'b0;
        lane_out  <= '0;
        r_idx     <= '0;
      end

      // Loopback samples the raw lane bus only while not transmitting.
      if (!active) begin
        recirc_data  <= in_data;
        recirc_valid <= |in_valid;
      end else begin
        recirc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/phy_tx_lane_mux.md
# phy_tx_lane_mux

Parametrised single-clock PHY transmit lane multiplexer. It accepts LANES parallel WIDTH-bit lanes with per-lane valids and buffers lane groups in a DEPTH-entry FIFO. It serialises each group onto one WIDTH-bit stream, one lane per clock. It replaces the fixed 4-lane, multi-clock (clk/clk2/clk4) mux tree with one clock and a ready handshake, and keeps the recirculation (loopback) path selected by `active`.

## Interface
- LANES, 4, number of input lanes (≥2)
- WIDTH, 8, bits per lane
- DEPTH, 4, FIFO depth in lane groups (power of 2, ≥2)
- IDLE, 8'h7C (WIDTH bits), symbol driven in empty slots
- clk  in  1  sole clock, all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- active  in  1  1 = transmit mode, 0 = recirculation mode
- in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- in_valid  in  LANES  per-lane valid
- in_ready  out  1  combinational: active && !full
- data_out  out  WIDTH  serialised lane data (registered)
- valid_out  out  1  data_out carries a valid lane (registered)
- lane_out  out  clog2(LANES)  lane index of data_out (registered)
- recirc_data  out  LANES*WIDTH  looped-back lane data (registered)
- recirc_valid  out  1  recirc_data valid (registered)

## Operation
- Write: at an edge where active && |in_valid && in_ready, push {in_valid, in_data} into the FIFO. Groups with in_valid == 0 are never stored.
- FIFO: write/read pointers of clog2(DEPTH) bits wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits. full = (count == DEPTH). Simultaneous push and pop leaves count unchanged.
- Serializer FSM:
  - IDLE: FIFO empty. Outputs data_out = IDLE, valid_out = 0, lane_out = 0.
  - SEND: presents head group lane idx on each edge: data_out <= head.data[idx], valid_out <= head.mask[idx], lane_out <= idx.
  - At the last lane, pop the head and reset idx. If the FIFO is still non-empty, stay in SEND with no bubble; otherwise go to IDLE.
- Invalid lane slots, macro undefined: data_out = IDLE, valid_out = 0, slot still consumes one cycle.
- Recirculation:
  - active = 0: recirc_data <= in_data and recirc_valid <= |in_valid on every edge. No FIFO writes.
  - active = 1: recirc_valid <= 0; recirc_data holds its value.
- Dropping active mid-stream: the current group and all queued groups drain normally. Only new writes stop.
- Reset (asserted at any time, including mid-group): FIFO empty, pointers 0, FSM IDLE, idx 0, data_out = IDLE, valid_out = 0, lane_out = 0, recirc_data = 0, recirc_valid = 0. in_ready follows active.

## Timing
- Latency: a group accepted at edge k into an empty FIFO with the FSM in IDLE shows its lane 0 on data_out after edge k+1.
- Throughput: one group per LANES cycles, back-to-back (macro undefined).
- in_ready does not see a same-cycle pop. When full, the write is refused even if a pop occurs on that edge.
- Recirculation latency: 1 cycle.

## Configuration
- PHY_TX_SKIP_INVALID_EN defined:
  - The serializer visits only lanes whose mask bit is set, in ascending order.
  - idx jumps to the next set bit; a group with n valid lanes takes n cycles.
  - valid_out is 1 in SEND; lane_out carries the real lane number.
- Undefined: every group takes exactly LANES cycles, with IDLE in empty slots as described above.

## Test plan
- Reset then active = 1; push {CC,DD,EE,FF} (lane3..0) with in_valid = 4'hF at edge 1 -> data_out FF,EE,DD,CC after edges 2..5 with valid_out = 1 and lane_out 0..3, then IDLE with valid_out = 0.
- Push {CC,DD,EE,FF} then {88,99,AA,BB} on consecutive edges -> eight contiguous valid outputs FF,EE,DD,CC,BB,AA,99,88 with no bubble.
- Push a group with in_valid = 4'b0100 and lane2 = 77:
  - macro undefined -> slots IDLE, IDLE, 77 (valid), IDLE.
  - PHY_TX_SKIP_INVALID_EN -> a single cycle: 77, lane_out = 2.
- Hold in_valid = 4'hF for DEPTH+2 edges with LANES = 4 -> in_ready drops after DEPTH accepted groups. Refused groups never appear; the accepted ones emerge in order.
- active = 0, in_data = {CC,DD,EE,FF}, in_valid = 4'hF -> recirc_data = that value and recirc_valid = 1 one edge later; valid_out stays 0 and in_ready = 0.
- Assert reset_L = 0 mid-group (after lane 1) -> all outputs return to reset values immediately. After release, the FIFO is empty and no stale lanes appear.
